// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and port ids.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    function automatic arb_state_t own_state(input logic port);
        return (port == PORT_LDR) ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin tie break with a bounded hold so a
// continuously requesting port cannot starve the other. Reads return one cycle after grant.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,

    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int HOLD_WIDTH = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = HOLD_WIDTH'(MAX_HOLD);
    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE = HOLD_WIDTH'(1);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [HOLD_WIDTH-1:0] cnt;
    logic [HOLD_WIDTH-1:0] cnt_nxt;
    logic                  last_gnt;
    logic                  grant_any;
    logic                  grant_port;
    logic                  owner;
    logic                  own_req;
    logic                  oth_req;
    logic                  rvalid0_q;
    logic                  rvalid1_q;

    always_comb begin
        grant_any  = 1'b0;
        grant_port = PORT_CPU;
        state_nxt  = state;
        cnt_nxt    = cnt;
        owner      = (state == OWN1) ? PORT_LDR : PORT_CPU;
        own_req    = owner ? req1 : req0;
        oth_req    = owner ? req0 : req1;

        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    grant_any  = 1'b1;
                    grant_port = ~last_gnt;
                end else if (req0 || req1) begin
                    grant_any  = 1'b1;
                    grant_port = req1 ? PORT_LDR : PORT_CPU;
                end
                if (grant_any) begin
                    state_nxt = own_state(grant_port);
                    cnt_nxt   = HOLD_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end
            OWN0, OWN1: begin
                // The owner keeps the memory until it lets go or exhausts its hold budget
                // while the other port is waiting.
                if (own_req && (!oth_req || cnt < HOLD_MAX)) begin
                    grant_any  = 1'b1;
                    grant_port = owner;
                    cnt_nxt    = (cnt == HOLD_MAX) ? cnt : cnt + HOLD_ONE;
                end else if (oth_req) begin
                    grant_any  = 1'b1;
                    grant_port = ~owner;
                    state_nxt  = own_state(~owner);
                    cnt_nxt    = HOLD_ONE;
                end else begin
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign gnt0 = grant_any & (grant_port == PORT_CPU) & ~rst;
    assign gnt1 = grant_any & (grant_port == PORT_LDR) & ~rst;

    assign mem_en    = gnt0 | gnt1;
    assign mem_we    = (gnt0 & we0) | (gnt1 & we1);
    assign mem_addr  = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
    assign mem_wdata = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last_gnt  <= PORT_LDR;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            if (grant_any) begin
                last_gnt <= grant_port;
            end
            rvalid0_q <= gnt0 & ~we0;
            rvalid1_q <= gnt1 & ~we1;
        end
    end

    // A read granted just before reset must not surface while reset is held.
    assign rvalid0 = rvalid0_q & ~rst;
    assign rvalid1 = rvalid1_q & ~rst;
    assign rdata0  = rvalid0 ? mem_rdata : '0;
    assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: two instances (MAX_HOLD 4 and 1), each with its own
// memory, compared against a grant-history reference model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [1:0][1:0]        req, we, gnt, rvalid;
    logic [1:0][1:0][31:0]  addr, wdata, rdata;
    logic [1:0]             mem_en, mem_we;
    logic [1:0][31:0]       mem_addr, mem_wdata;

    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(i));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] mem_rdata_g;
        logic [31:0] mem_dev [256];

        dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_HOLD(g == 0 ? 4 : 1)) u_dut (
            .clk(clk), .rst(rst),
            .req0(req[g][0]), .we0(we[g][0]), .addr0(addr[g][0]), .wdata0(wdata[g][0]),
            .gnt0(gnt[g][0]), .rvalid0(rvalid[g][0]), .rdata0(rdata[g][0]),
            .req1(req[g][1]), .we1(we[g][1]), .addr1(addr[g][1]), .wdata1(wdata[g][1]),
            .gnt1(gnt[g][1]), .rvalid1(rvalid[g][1]), .rdata1(rdata[g][1]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata_g)
        );

        initial begin
            for (int i = 0; i < 256; i++) mem_dev[i] <= init_word(i);
        end

        // Garbage on idle cycles so an ungated rdata shows up.
        always @(posedge clk) begin
            if (mem_en[g] && mem_we[g]) mem_dev[mem_addr[g][7:0]] <= mem_wdata[g];
            if (mem_en[g] && !mem_we[g]) mem_rdata_g <= mem_dev[mem_addr[g][7:0]];
            else mem_rdata_g <= $urandom;
        end
    end

    typedef struct {
        int          cyc;
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rd_t;

    acc_t        acc_q [2][$];
    rd_t         rd_q  [4][$];
    int          gnt_log [2][$];
    logic [31:0] last_rd [2][2];
    logic [31:0] ref_mem [2][256];
    bit          busy [2];
    bit          last [2];
    int          run  [2];
    int          max_hold [2] = '{4, 1};
    int          cyc;
    int          tests;
    int          fails;

    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, d, cyc, act, exp);
        end
    endtask

    task automatic flag(input int d, input string nm, input int c);
        tests++;
        fails++;
        $display("FAIL %s dut%0d cyc %0d: got event at/for cycle %0d, expected none", nm, d, cyc, c);
    endtask

    // Reference: the port that has just been granted run[] times in a row keeps priority
    // under contention until run reaches max_hold; otherwise the port not granted last wins.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            logic w;
            acc_t a;
            rd_t  r;
            if (rst) begin
                busy[d] = 0;
                last[d] = 1;
                run[d]  = 0;
                rd_q[d*2].delete();
                rd_q[d*2+1].delete();
            end else if (!(req[d][0] || req[d][1])) begin
                busy[d] = 0;
            end else begin
                if (req[d][0] && req[d][1])
                    w = (busy[d] && run[d] < max_hold[d]) ? last[d] : ~last[d];
                else
                    w = req[d][1];
                run[d]  = (busy[d] && w == last[d]) ? run[d] + 1 : 1;
                busy[d] = 1;
                last[d] = w;
                a.cyc = cyc; a.port = w; a.we = we[d][w];
                a.addr = addr[d][w]; a.wdata = wdata[d][w];
                acc_q[d].push_back(a);
                if (we[d][w]) begin
                    ref_mem[d][addr[d][w][7:0]] = wdata[d][w];
                end else begin
                    r.cyc = cyc + 1;
                    r.data = ref_mem[d][addr[d][w][7:0]];
                    rd_q[d*2+w].push_back(r);
                end
            end
        end
    endtask

    task automatic check_dut(input int d);
        acc_t a;
        rd_t  r;
        chk(d, "gnt_exclusive", 32'(gnt[d][0] & gnt[d][1]), 0);
        chk(d, "mem_en_is_or", 32'(mem_en[d]), 32'(gnt[d][0] | gnt[d][1]));
        if (rst) begin
            chk(d, "rst_gnt", 32'(gnt[d]), 0);
            chk(d, "rst_rvalid", 32'(rvalid[d]), 0);
            chk(d, "rst_rdata0", rdata[d][0], 0);
            chk(d, "rst_rdata1", rdata[d][1], 0);
        end
        while (acc_q[d].size() > 0 && acc_q[d][0].cyc < cyc) begin
            a = acc_q[d].pop_front();
            flag(d, "missed_access", a.cyc);
        end
        if (mem_en[d]) begin
            gnt_log[d].push_back(int'(gnt[d][1]));
            if (acc_q[d].size() == 0) begin
                flag(d, "unexpected_access", cyc);
            end else begin
                a = acc_q[d].pop_front();
                chk(d, "acc_cycle", 32'(cyc), 32'(a.cyc));
                chk(d, "acc_port", 32'(gnt[d][1]), 32'(a.port));
                chk(d, "acc_we", 32'(mem_we[d]), 32'(a.we));
                chk(d, "acc_addr", mem_addr[d], a.addr);
                chk(d, "acc_wdata", mem_wdata[d], a.wdata);
            end
        end else begin
            chk(d, "idle_mem_we", 32'(mem_we[d]), 0);
            chk(d, "idle_mem_addr", mem_addr[d], 0);
            chk(d, "idle_mem_wdata", mem_wdata[d], 0);
        end
        for (int p = 0; p < 2; p++) begin
            while (rd_q[d*2+p].size() > 0 && rd_q[d*2+p][0].cyc < cyc) begin
                r = rd_q[d*2+p].pop_front();
                flag(d, p ? "missed_read1" : "missed_read0", r.cyc);
            end
            if (rvalid[d][p]) begin
                last_rd[d][p] = rdata[d][p];
                if (rd_q[d*2+p].size() == 0) begin
                    flag(d, p ? "unexpected_rvalid1" : "unexpected_rvalid0", cyc);
                end else begin
                    r = rd_q[d*2+p].pop_front();
                    chk(d, p ? "rd1_cycle" : "rd0_cycle", 32'(cyc), 32'(r.cyc));
                    chk(d, p ? "rd1_data" : "rd0_data", rdata[d][p], r.data);
                end
            end else begin
                chk(d, p ? "rdata1_idle" : "rdata0_idle", rdata[d][p], 0);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) check_dut(d);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        req = '0; we = '0; addr = '0; wdata = '0;
    endtask

    task automatic set_both(input int p, input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] wd);
        for (int d = 0; d < 2; d++) begin
            req[d][p] = r; we[d][p] = w; addr[d][p] = a; wdata[d][p] = wd;
        end
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) gnt_log[d].delete();
    endtask

    task automatic check_log(input int d, input string nm, input int exp[$]);
        chk(d, {nm, "_len"}, 32'(gnt_log[d].size() >= exp.size()), 1);
        for (int i = 0; i < exp.size() && i < gnt_log[d].size(); i++)
            chk(d, nm, 32'(gnt_log[d][i]), 32'(exp[i]));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) ref_mem[d][i] = init_word(i);
            last_rd[d][0] = '0;
            last_rd[d][1] = '0;
        end
        rst = 1'b1;
        idle_inputs();
        repeat (2) begin tick(); model_step(); end

        // Single read from port 0 right after reset.
        tick(); rst = 1'b0; idle_inputs(); set_both(0, 1, 0, 32'h10, 0); model_step();
        repeat (2) begin tick(); idle_inputs(); model_step(); end
        for (int d = 0; d < 2; d++) chk(d, "first_read", last_rd[d][0], 32'hDEAD_BEEF);

        // Continuous tie after reset.
        tick(); rst = 1'b1; idle_inputs(); model_step();
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            tick(); rst = 1'b0;
            set_both(0, 1, 0, 32'($urandom_range(0, 31)), 0);
            set_both(1, 1, 0, 32'($urandom_range(0, 31)), 0);
            model_step();
        end
        tick(); idle_inputs(); model_step();
        check_log(0, "tie_hold4", '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0});
        check_log(1, "tie_hold1", '{0, 1, 0, 1, 0, 1});

        // Sole writer on port 1 saturates its hold, then yields at once to port 0.
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            tick(); idle_inputs(); set_both(1, 1, 1, 32'h20, 32'h1234); model_step();
        end
        tick(); set_both(0, 1, 0, 32'h20, 0); model_step();
        repeat (2) begin tick(); idle_inputs(); model_step(); end
        for (int d = 0; d < 2; d++) begin
            check_log(d, "sole_writer", '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0});
            chk(d, "readback", last_rd[d][0], 32'h1234);
        end

        // Reset right after a read grant drops the pending response.
        tick(); idle_inputs(); set_both(0, 1, 0, 32'h10, 0); model_step();
        tick(); rst = 1'b1; idle_inputs(); model_step();
        clear_logs();
        tick(); rst = 1'b0; set_both(0, 1, 0, 32'h3, 0); set_both(1, 1, 0, 32'h4, 0); model_step();
        repeat (2) begin tick(); idle_inputs(); model_step(); end
        for (int d = 0; d < 2; d++) check_log(d, "tie_after_rst", '{0});

        // Quiet period.
        clear_logs();
        repeat (5) begin tick(); idle_inputs(); model_step(); end
        for (int d = 0; d < 2; d++) chk(d, "quiet_grants", 32'(gnt_log[d].size()), 0);

        // Randomized traffic with occasional resets.
        repeat (3000) begin
            tick();
            rst = ($urandom_range(0, 99) == 0);
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    req[d][p]   = ($urandom_range(0, 9) < 6);
                    we[d][p]    = ($urandom_range(0, 2) == 0);
                    addr[d][p]  = 32'($urandom_range(0, 31));
                    wdata[d][p] = $urandom;
                end
            end
            model_step();
        end

        repeat (4) begin tick(); rst = 1'b0; idle_inputs(); model_step(); end
        for (int d = 0; d < 2; d++) begin
            chk(d, "acc_q_drained", 32'(acc_q[d].size()), 0);
            chk(d, "rd0_q_drained", 32'(rd_q[d*2].size()), 0);
            chk(d, "rd1_q_drained", 32'(rd_q[d*2+1].size()), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data memory between two requesters. Port 0 is the CPU load/store path (ALU result address, RD2 write data). Port 1 is the program loader/debug port. Each cycle the block issues at most one access to the memory. Arbitration uses a three-state FSM with round-robin priority and a bounded-hold counter, so neither port can starve the other. Read data returns one cycle after the grant.

Parameters:
ADDR_WIDTH, 32, width of access address
DATA_WIDTH, 32, width of read/write data
MAX_HOLD, 4, max consecutive grants to one port while the other is requesting (legal range >=1)
HOLD_WIDTH, $clog2(MAX_HOLD+1), localparam, hold-counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req0  in  1  port 0 access request; held until gnt0
we0  in  1  port 0 write enable (0 = read)
addr0  in  ADDR_WIDTH  port 0 address
wdata0  in  DATA_WIDTH  port 0 write data
gnt0  out  1  port 0 granted this cycle (access issued this cycle)
rvalid0  out  1  port 0 read data valid
rdata0  out  DATA_WIDTH  port 0 read data
req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1  same as port 0, for port 1
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en with !mem_we

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, cnt=0, last_gnt=1, so port 0 wins the first tie.
  - rvalid0/1=0.
  - While rst=1: gnt0/1=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata0/1=0.
- Grant timing:
  - Grant is combinational from req and the registered state. gntN is high in the same cycle the access is driven to memory.
  - Never gntN without reqN. Never gnt0 and gnt1 together.
  - mem_en = gnt0|gnt1. mem_we/addr/wdata are muxed from the granted port, all 0 when mem_en=0.
- Read return: rvalidN registered, set at T+1 iff gntN & !weN at T. rdataN = mem_rdata while rvalidN, else 0. Writes produce no response.
- Throughput: one access per cycle; back-to-back grants allowed.
- FSM states (arb_state_t): IDLE, OWN0, OWN1.
  - IDLE:
    - no req: stay, cnt=0.
    - one req: grant it, go OWNx, cnt=1.
    - both req: grant port != last_gnt, go OWNx, cnt=1.
  - OWNx:
    - reqx & (!req_other | cnt<MAX_HOLD): grant x, stay, cnt = min(cnt+1, MAX_HOLD).
    - reqx & req_other & cnt==MAX_HOLD: grant other, go OWNother, cnt=1.
    - !reqx & req_other: grant other, go OWNother, cnt=1.
    - neither req: go IDLE, cnt=0.
  - last_gnt updates on every grant and holds otherwise.
- Boundaries:
  - MAX_HOLD=1 gives strict alternation under contention.
  - A sole requester is granted every cycle indefinitely; cnt saturates without wrapping.
  - Request dropped before grant: legal, nothing issued.
  - rst mid-read: pending rvalid is discarded, with no rvalid the cycle after reset.
  - Simultaneous rvalid of a read from T and new grant at T+1: both occur, independent.

Decomposition:
- Package dmem_arb_pkg: typedef enum logic [1:0] arb_state_t {IDLE, OWN0, OWN1}; localparams PORT_CPU=1'b0, PORT_LDR=1'b1.
- No sub-module. FSM, hold counter, port mux and rvalid pipeline stay in one module.

Test Plan:
- Reset then req0=1, we0=0, addr0=0x10, memory[0x10]=0xDEADBEEF:
  - gnt0=1 same cycle, mem_addr=0x10.
  - Next cycle rvalid0=1, rdata0=0xDEADBEEF; rvalid1=0.
- Tie after reset, req0=req1=1 held, MAX_HOLD=4:
  - Grant sequence 0,0,0,0,1,1,1,1,0,...
  - Never both gnt high.
- MAX_HOLD=1, both req held 6 cycles: grants alternate 0,1,0,1,0,1.
- req1 alone, write addr1=0x20, wdata1=0x1234 for 10 cycles:
  - gnt1 every cycle, mem_we=1, cnt saturates at 4.
  - Read-back via port 0 returns 0x1234.
- Port 0 read granted at T, rst=1 at T+1:
  - rvalid0=0 at T+1 and T+2; state IDLE.
  - First tie after reset goes to port 0.
- No requests for 5 cycles: mem_en=0, mem_addr=0, mem_wdata=0, gnt0/1=0 throughout; state IDLE.
